// File: rtl/hit_pkg.sv
// hit_pkg: shared types and constants for the hit scoring front end
package hit_pkg;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] SCORE_REG_DEFAULT = 5'd30;
  typedef enum logic [1:0] {IDLE, ARMED, COOL} inj_state_t;
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: two-flop synchronizer, stability counter and press strobe for an active-low button
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_stable,
  output logic press_strobe
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic sync_out, accept;
  assign sync_out = sync[1];
  assign accept = (sync_out != btn_stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
      cnt <= '0;
      btn_stable <= 1'b1;
      press_strobe <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      cnt <= (sync_out == btn_stable || accept) ? '0 : cnt + 1'b1;
      btn_stable <= accept ? sync_out : btn_stable;
      // high for the first cycle btn_stable reads pressed
      press_strobe <= accept && !sync_out;
    end
  end
endmodule

// File: rtl/hit_score_injector.sv
// hit_score_injector: classifies debounced presses as hit/miss and injects the pending hit count into the score register
module hit_score_injector
  import hit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PEND_W = 3,
  parameter logic [REG_IDX_W-1:0] SCORE_REG = SCORE_REG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_raw,
  input  logic                 target_lit,
  input  logic                 cpu_we,
  input  logic [REG_IDX_W-1:0] cpu_wreg,
  input  logic [31:0]          cpu_wdata,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_wreg,
  output logic [31:0]          rf_wdata,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [PEND_W-1:0]    pending,
  output logic                 overflow
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  inj_state_t state;
  logic btn_stable, press_strobe, press, lit_q, grant;
  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_stable(btn_stable),
    .press_strobe(press_strobe)
  );
  assign press = press_strobe && !btn_stable;
  // grant steals the port only on cycles the CPU leaves it idle
  assign grant = (state == ARMED) && !cpu_we;
  assign rf_we = grant || cpu_we;
  assign rf_wreg = grant ? SCORE_REG : cpu_wreg;
  assign rf_wdata = grant ? 32'(pending) : cpu_wdata;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lit_q <= 1'b0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      pending <= '0;
      overflow <= 1'b0;
      state <= IDLE;
    end else begin
      lit_q <= target_lit;
      hit_pulse <= press && lit_q;
      miss_pulse <= press && !lit_q;
      // a hit landing on the grant edge becomes the new pending count
      pending <= grant ? PEND_W'(hit_pulse)
               : (hit_pulse && pending != PEND_MAX) ? pending + 1'b1 : pending;
      overflow <= overflow || (hit_pulse && !grant && pending == PEND_MAX);
      state <= (state == IDLE) ? ((pending != '0) ? ARMED : IDLE)
             : (state == ARMED) ? (grant ? COOL : ARMED) : IDLE;
    end
  end
endmodule

// File: tb/tb_hit_score_injector.sv
// tb_hit_score_injector: scoreboard bench for press classification, pending count and score injection
module tb_hit_score_injector;
  logic clk = 1'b0, reset, btn_raw, target_lit, cpu_we;
  logic [4:0] cpu_wreg, rf_wreg;
  logic [31:0] cpu_wdata, rf_wdata;
  logic rf_we, hit_pulse, miss_pulse, overflow;
  logic [2:0] pending;
  int total = 0, passed = 0;
  logic [31:0] inj_q[$];
  byte ev_q[$];
  localparam byte EV_HIT = 8'h48, EV_MISS = 8'h4D;

  hit_score_injector #(.DEBOUNCE_CYCLES(4), .PEND_W(3)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .target_lit(target_lit),
    .cpu_we(cpu_we), .cpu_wreg(cpu_wreg), .cpu_wdata(cpu_wdata),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic press(input logic lit);
    target_lit = lit;
    btn_raw = 1'b0;
    ev_q.push_back(lit ? EV_HIT : EV_MISS);
    repeat (10) nxt();
    btn_raw = 1'b1;
    repeat (10) nxt();
  endtask

  // monitor: pops expectations whenever the DUT presents an event or an injection
  initial forever begin
    @(negedge clk);
    #3;
    if (hit_pulse || miss_pulse) begin
      if (ev_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_event: hit=%0b miss=%0b with nothing expected at %0t", hit_pulse, miss_pulse, $time);
      end else chk("event_kind", {24'd0, hit_pulse ? EV_HIT : EV_MISS}, {24'd0, ev_q.pop_front()});
    end
    if (rf_we && !cpu_we) begin
      if (inj_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_inject: data %0h with nothing expected at %0t", rf_wdata, $time);
      end else begin
        chk("inject_data", rf_wdata, inj_q.pop_front());
        chk("inject_reg", {27'd0, rf_wreg}, 32'd30);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; btn_raw = 1'b1; target_lit = 1'b1;
    cpu_we = 1'b0; cpu_wreg = 5'd4; cpu_wdata = 32'h1111;
    nxt();
    chk("rst_pending", {29'd0, pending}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_hit", {31'd0, hit_pulse}, 0);
    chk("rst_rf_we", {31'd0, rf_we}, 0);
    chk("rst_rf_wreg", {27'd0, rf_wreg}, 4);
    reset = 1'b1;
    repeat (3) nxt();
    // 1: exact latency and first injection
    btn_raw = 1'b0;
    ev_q.push_back(EV_HIT);
    inj_q.push_back(1);
    repeat (6) nxt();
    chk("t1_hit_c6", {31'd0, hit_pulse}, 0);
    nxt();
    chk("t1_hit_c7", {31'd0, hit_pulse}, 1);
    nxt();
    chk("t1_pend_c8", {29'd0, pending}, 1);
    nxt();
    chk("t1_rf_we_c9", {31'd0, rf_we}, 1);
    chk("t1_rf_wreg_c9", {27'd0, rf_wreg}, 30);
    chk("t1_rf_wdata_c9", rf_wdata, 1);
    nxt();
    chk("t1_pend_c10", {29'd0, pending}, 0);
    btn_raw = 1'b1;
    repeat (12) nxt();
    // 2: bouncing input yields one hit
    cpu_we = 1'b1; cpu_wreg = 5'd3; cpu_wdata = 32'h55;
    for (int i = 0; i < 6; i++) begin
      btn_raw = i[0];
      repeat (2) nxt();
    end
    btn_raw = 1'b0;
    ev_q.push_back(EV_HIT);
    repeat (20) nxt();
    chk("t2_pending", {29'd0, pending}, 1);
    cpu_we = 1'b0;
    inj_q.push_back(1);
    repeat (4) nxt();
    chk("t2_pend_after", {29'd0, pending}, 0);
    btn_raw = 1'b1;
    repeat (10) nxt();
    // 3: miss, rf follows cpu throughout
    target_lit = 1'b0; btn_raw = 1'b0;
    ev_q.push_back(EV_MISS);
    for (int i = 0; i < 20; i++) begin
      nxt();
      chk("t3_rf_we", {31'd0, rf_we}, {31'd0, cpu_we});
      chk("t3_rf_wreg", {27'd0, rf_wreg}, {27'd0, cpu_wreg});
      chk("t3_rf_wdata", rf_wdata, cpu_wdata);
      cpu_we = i[0]; cpu_wreg = 5'(i); cpu_wdata = 32'(i * 3);
    end
    cpu_we = 1'b0; btn_raw = 1'b1;
    repeat (10) nxt();
    chk("t3_pending", {29'd0, pending}, 0);
    // 4: CPU holds the port, then first free cycle injects 2
    cpu_we = 1'b1; cpu_wreg = 5'd5; cpu_wdata = 32'hAA;
    press(1'b1);
    press(1'b1);
    for (int i = 0; i < 20; i++) begin
      nxt();
      chk("t4_rf_we", {31'd0, rf_we}, 1);
      chk("t4_rf_wreg", {27'd0, rf_wreg}, 5);
      chk("t4_rf_wdata", rf_wdata, 32'hAA);
    end
    chk("t4_pending", {29'd0, pending}, 2);
    cpu_we = 1'b0;
    inj_q.push_back(2);
    #1;
    chk("t4_grant_we", {31'd0, rf_we}, 1);
    chk("t4_grant_wreg", {27'd0, rf_wreg}, 30);
    chk("t4_grant_wdata", rf_wdata, 2);
    repeat (4) nxt();
    chk("t4_pend_after", {29'd0, pending}, 0);
    // 5: saturation and sticky overflow
    cpu_we = 1'b1;
    repeat (8) press(1'b1);
    chk("t5_pending", {29'd0, pending}, 7);
    chk("t5_overflow", {31'd0, overflow}, 1);
    cpu_we = 1'b0;
    inj_q.push_back(7);
    repeat (4) nxt();
    chk("t5_overflow_kept", {31'd0, overflow}, 1);
    chk("t5_pend_after", {29'd0, pending}, 0);
    // 6a: hit coincident with grant
    cpu_we = 1'b1; cpu_wreg = 5'd7; cpu_wdata = 32'h1234;
    repeat (3) press(1'b1);
    chk("t6a_pending", {29'd0, pending}, 3);
    target_lit = 1'b1; btn_raw = 1'b0;
    ev_q.push_back(EV_HIT);
    repeat (7) nxt();
    chk("t6a_hit_c7", {31'd0, hit_pulse}, 1);
    cpu_we = 1'b0;
    inj_q.push_back(3);
    inj_q.push_back(1);
    nxt();
    chk("t6a_pend_carry", {29'd0, pending}, 1);
    chk("t6a_cool_we", {31'd0, rf_we}, 0);
    nxt();
    chk("t6a_idle_we", {31'd0, rf_we}, 0);
    nxt();
    chk("t6a_second_we", {31'd0, rf_we}, 1);
    chk("t6a_second_data", rf_wdata, 1);
    nxt();
    chk("t6a_pend_after", {29'd0, pending}, 0);
    btn_raw = 1'b1;
    repeat (10) nxt();
    // 6b: reset while ARMED
    cpu_we = 1'b1; cpu_wreg = 5'd9; cpu_wdata = 32'h77;
    press(1'b1);
    chk("t6b_pending", {29'd0, pending}, 1);
    reset = 1'b0; cpu_we = 1'b0;
    #1;
    chk("t6b_rf_we", {31'd0, rf_we}, 0);
    chk("t6b_pend_rst", {29'd0, pending}, 0);
    chk("t6b_ovf_rst", {31'd0, overflow}, 0);
    nxt();
    cpu_we = 1'b1; cpu_wreg = 5'd30; cpu_wdata = 32'hDEAD;
    nxt();
    chk("t6b_pass_we", {31'd0, rf_we}, 1);
    chk("t6b_pass_wreg", {27'd0, rf_wreg}, 30);
    chk("t6b_pass_wdata", rf_wdata, 32'hDEAD);
    reset = 1'b1; cpu_we = 1'b0;
    repeat (6) nxt();
    chk("t6b_pend_idle", {29'd0, pending}, 0);
    chk("t6b_rf_we_idle", {31'd0, rf_we}, 0);
    chk("inj_q_empty", inj_q.size(), 0);
    chk("ev_q_empty", ev_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
